// File: rtl/spi_pwm_cfg_rx.sv
// SPI mode-0 target that decodes 32-bit {cmd, data} frames into the PWM compare value and enable.
// Optional feature macro SPI_READBACK_EN: shift status byte and compare value out on SPI_MISO.
module spi_pwm_cfg_rx #(
  parameter int CLOCK_FREQUENCY = 48_000_000,
  parameter int PWM_FREQUENCY   = 400,
  parameter int COMPARE_MAX     = CLOCK_FREQUENCY / PWM_FREQUENCY,
  parameter int COMPARE_W       = $clog2(COMPARE_MAX + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SPI_SCK,
  input  logic                 SPI_CS_N,
  input  logic                 SPI_MOSI,
  output logic                 SPI_MISO,
  output logic [COMPARE_W-1:0] compare_value,
  output logic                 pwm_enable,
  output logic                 compare_update,
  output logic                 clamped,
  output logic                 frame_err
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, COMMIT, OVER, WAIT_CS} state_t;

  localparam logic [23:0] COMPARE_MAX_24 = 24'(COMPARE_MAX);

  state_t      state, next_state;
  logic [2:0]  sck_sync, cs_sync, mosi_sync;
  logic        sck_rise, cs_high, cs_fall, mosi_bit;
  logic [31:0] rx_shift;
  logic [5:0]  bit_cnt;
  logic        over_err_seen;
  logic        start_frame, abort_frame, over_bit, shifting;
  logic [7:0]  cmd;
  logic [23:0] data, cmp_src;
  logic        data_over;
  logic [COMPARE_W-1:0] cmp_new;

  // Bit 0/1 are the metastability stages, bit 2 is the history flop used for edge detection.
  // CS_N resets low so a reset taken mid-frame waits for a genuine CS_N high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[1:0], SPI_SCK};
      cs_sync   <= {cs_sync[1:0], SPI_CS_N};
      mosi_sync <= {mosi_sync[1:0], SPI_MOSI};
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign cs_high  = cs_sync[1];
  assign cs_fall  = ~cs_sync[1] & cs_sync[2];
  assign mosi_bit = mosi_sync[2];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= WAIT_CS;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    abort_frame = 1'b0;
    over_bit    = 1'b0;
    unique case (state)
      WAIT_CS: if (cs_high) next_state = IDLE;
      IDLE: begin
        if (cs_fall) begin
          next_state  = CMD;
          start_frame = 1'b1;
        end
      end
      CMD: begin
        if (cs_high) begin
          next_state  = IDLE;
          abort_frame = 1'b1;
        end else if (sck_rise && bit_cnt == 6'd7) begin
          next_state = DATA;
        end
      end
      DATA: begin
        if (cs_high) begin
          next_state  = IDLE;
          abort_frame = 1'b1;
        end else if (sck_rise && bit_cnt == 6'd31) begin
          next_state = COMMIT;
        end
      end
      COMMIT: next_state = OVER;
      OVER: begin
        if (cs_high) next_state = IDLE;
        else if (sck_rise && !over_err_seen) over_bit = 1'b1;
      end
      default: next_state = WAIT_CS;
    endcase
  end

  assign shifting = (state == CMD || state == DATA) && sck_rise && !cs_high;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_shift      <= '0;
      bit_cnt       <= '0;
      over_err_seen <= 1'b0;
    end else begin
      if (start_frame) begin
        bit_cnt       <= '0;
        over_err_seen <= 1'b0;
      end else if (shifting) begin
        rx_shift <= {rx_shift[30:0], mosi_bit};
        bit_cnt  <= bit_cnt + 6'd1;
      end
      if (over_bit) over_err_seen <= 1'b1;
    end
  end

  // The clamp decision uses all 24 data bits so values above the output width saturate instead of wrapping.
  assign cmd       = rx_shift[31:24];
  assign data      = rx_shift[23:0];
  assign cmp_src   = (cmd == 8'h03) ? {1'b0, data[22:0]} : data;
  assign data_over = cmp_src > COMPARE_MAX_24;
  assign cmp_new   = data_over ? COMPARE_W'(COMPARE_MAX) : cmp_src[COMPARE_W-1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      compare_value  <= '0;
      pwm_enable     <= 1'b0;
      compare_update <= 1'b0;
      clamped        <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      compare_update <= 1'b0;
      clamped        <= 1'b0;
      frame_err      <= abort_frame | over_bit;
      if (state == COMMIT) begin
        case (cmd)
          8'h01: begin
            compare_value  <= cmp_new;
            clamped        <= data_over;
            compare_update <= 1'b1;
          end
          8'h02: begin
            pwm_enable     <= data[0];
            compare_update <= 1'b1;
          end
          8'h03: begin
            compare_value  <= cmp_new;
            pwm_enable     <= data[23];
            clamped        <= data_over;
            compare_update <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic [31:0] tx_shift;
  logic        sck_fall;

  assign sck_fall = ~sck_sync[1] & sck_sync[2];

  // The DATA reload carries a leading pad bit because the next SCK fall shifts it out before sampling.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_shift <= '0;
    end else if (start_frame) begin
      tx_shift <= {6'b101001, pwm_enable, 1'b1, 24'h0};
    end else if (state == CMD && next_state == DATA) begin
      tx_shift <= {1'b0, 24'(compare_value), 7'h0};
    end else if (sck_fall && (state == CMD || state == DATA)) begin
      tx_shift <= {tx_shift[30:0], 1'b0};
    end
  end

  assign SPI_MISO = tx_shift[31] & ~SPI_CS_N & (state == CMD || state == DATA);
`else
  assign SPI_MISO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_pwm_cfg_rx.sv
// Self-checking bench for spi_pwm_cfg_rx: table-driven frames plus abort, overlong and reset sequences.
// Pulse outputs are checked by a scoreboard queue filled when each frame is driven.
module tb_spi_pwm_cfg_rx;

  typedef struct {
    logic [31:0] frame;
    logic        upd;
    logic [16:0] exp_cmp;
    logic        exp_en;
    logic        exp_clamp;
  } vec_t;

  typedef struct {
    logic        upd;
    logic        ferr;
    logic        clamp;
    logic [16:0] cmp;
    logic        en;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck, cs_n, mosi;
  logic        miso;
  logic [16:0] compare_value;
  logic        pwm_enable, compare_update, clamped, frame_err;

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   rise_cycle = 0;
  int   lat;
  logic prev_upd   = 1'b0;
  ev_t  exp_q[$];
  ev_t  mon_ev;

  logic [16:0] cur_cmp;
  logic        cur_en;
  vec_t        vecs[11];

  spi_pwm_cfg_rx dut (
    .CLK            (clk),
    .RST            (rst),
    .SPI_SCK        (sck),
    .SPI_CS_N       (cs_n),
    .SPI_MOSI       (mosi),
    .SPI_MISO       (miso),
    .compare_value  (compare_value),
    .pwm_enable     (pwm_enable),
    .compare_update (compare_update),
    .clamped        (clamped),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard: every update/error pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (compare_update || frame_err) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_event upd=%0b ferr=%0b cmp=%0d required no event",
                 compare_update, frame_err, compare_value);
      end else begin
        mon_ev = exp_q.pop_front();
        if (compare_update !== mon_ev.upd || frame_err !== mon_ev.ferr || clamped !== mon_ev.clamp ||
            compare_value !== mon_ev.cmp || pwm_enable !== mon_ev.en) begin
          mismatched++;
          $display("[TB] FAIL event got upd=%0b ferr=%0b clamp=%0b cmp=%0d en=%0b required upd=%0b ferr=%0b clamp=%0b cmp=%0d en=%0b",
                   compare_update, frame_err, clamped, compare_value, pwm_enable,
                   mon_ev.upd, mon_ev.ferr, mon_ev.clamp, mon_ev.cmp, mon_ev.en);
        end
      end
    end
    if (compare_update) begin
      compared++;
      lat = cyc - rise_cycle;
      if (prev_upd || lat < 4 || lat > 5) begin
        mismatched++;
        $display("[TB] FAIL update_timing got latency=%0d prev_high=%0b required latency 4..5 single pulse",
                 lat, prev_upd);
      end
    end
    if (clamped && !compare_update) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL clamp_alone got clamped=1 update=0 required clamped only with update");
    end
    prev_upd = compare_update;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] readback_exp(input logic en, input logic [16:0] cmp);
`ifdef SPI_READBACK_EN
    return {6'b101001, en, 1'b1, 7'h0, cmp};
`else
    return 32'h0;
`endif
  endfunction

  task automatic compare_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s got 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push_ev(input logic upd, input logic ferr, input logic clamp,
                         input logic [16:0] cmp, input logic en);
    ev_t e;
    e.upd = upd; e.ferr = ferr; e.clamp = clamp; e.cmp = cmp; e.en = en;
    exp_q.push_back(e);
  endtask

  // bits is MSB-aligned: bit i of the transfer is bits[39-i]; SCK runs at CLK/16.
  task automatic spi_bits(input logic [39:0] bits, input int nbits, output logic [31:0] miso_bits);
    miso_bits = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = bits[39-i];
      repeat (8) @(negedge clk);
      if (i < 32) miso_bits = {miso_bits[30:0], miso};
      sck        = 1'b1;
      rise_cycle = cyc;
      repeat (8) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic spi_send(input logic [39:0] bits, input int nbits, output logic [31:0] miso_bits);
    @(negedge clk);
    cs_n = 1'b0;
    mosi = bits[39];
    spi_bits(bits, nbits, miso_bits);
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [16:0] exp_cmp, input logic exp_en);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL %s_pending got %0d events outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
    compare_val({name, "_cmp"}, 32'(compare_value), 32'(exp_cmp));
    compare_val({name, "_en"}, 32'(pwm_enable), 32'(exp_en));
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    logic [31:0] rb;
    logic [31:0] rb_exp;
    rb_exp = readback_exp(cur_en, cur_cmp);
    if (v.upd) push_ev(1'b1, 1'b0, v.exp_clamp, v.exp_cmp, v.exp_en);
    spi_send({v.frame, 8'h00}, 32, rb);
    compare_val($sformatf("vec%0d_miso", idx), rb, rb_exp);
    checkOutput($sformatf("vec%0d", idx), v.exp_cmp, v.exp_en);
    cur_cmp = v.exp_cmp;
    cur_en  = v.exp_en;
  endtask

  initial begin
    logic [31:0] rb;

    vecs[0]  = '{32'h0100EA60, 1'b1, 17'd60000,  1'b0, 1'b0};
    vecs[1]  = '{32'h01FFFFFF, 1'b1, 17'd120000, 1'b0, 1'b1};
    vecs[2]  = '{32'h0380EA60, 1'b1, 17'd60000,  1'b1, 1'b0};
    vecs[3]  = '{32'h7E123456, 1'b0, 17'd60000,  1'b1, 1'b0};
    vecs[4]  = '{32'h02000000, 1'b1, 17'd60000,  1'b0, 1'b0};
    vecs[5]  = '{32'h03FFFFFF, 1'b1, 17'd120000, 1'b1, 1'b1};
    vecs[6]  = '{32'h0101D4C0, 1'b1, 17'd120000, 1'b1, 1'b0};
    vecs[7]  = '{32'h0101D4C1, 1'b1, 17'd120000, 1'b1, 1'b1};
    vecs[8]  = '{32'h01000000, 1'b1, 17'd0,      1'b1, 1'b0};
    vecs[9]  = '{32'h02FFFFFE, 1'b1, 17'd0,      1'b0, 1'b0};
    vecs[10] = '{32'h01020000, 1'b1, 17'd120000, 1'b0, 1'b1};

    rst  = 1'b1;
    cs_n = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    cur_cmp = '0;
    cur_en  = 1'b0;
    repeat (4) @(negedge clk);
    compare_val("reset_cmp", 32'(compare_value), 32'h0);
    compare_val("reset_en", 32'(pwm_enable), 32'h0);
    compare_val("reset_pulses", {29'h0, compare_update, clamped, frame_err}, 32'h0);
    compare_val("reset_miso", 32'(miso), 32'h0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 11; i++) applyStimulus(i, vecs[i]);

    // CS_N raised after 20 bits: error pulse, value untouched, next frame still accepted.
    push_ev(1'b0, 1'b1, 1'b0, 17'd120000, 1'b0);
    spi_send({32'h01000100, 8'h00}, 20, rb);
    checkOutput("abort", 17'd120000, 1'b0);
    push_ev(1'b1, 1'b0, 1'b0, 17'd256, 1'b0);
    spi_send({32'h01000100, 8'h00}, 32, rb);
    checkOutput("after_abort", 17'd256, 1'b0);

    // 40-bit frame: commit on bit 32, then exactly one error pulse for the extra byte.
    push_ev(1'b1, 1'b0, 1'b0, 17'd100, 1'b0);
    push_ev(1'b0, 1'b1, 1'b0, 17'd100, 1'b0);
    spi_send({32'h01000064, 8'hFF}, 40, rb);
    checkOutput("overlong", 17'd100, 1'b0);

    spi_send({32'h7E000000, 8'h00}, 32, rb);
    checkOutput("unknown_cmd", 17'd100, 1'b0);

    // Reset mid-frame, keep clocking a full frame with CS_N low: it must be ignored.
    @(negedge clk);
    cs_n = 1'b0;
    spi_bits({32'h01000055, 8'h00}, 10, rb);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compare_val("midreset_cmp", 32'(compare_value), 32'h0);
    compare_val("midreset_en", 32'(pwm_enable), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits({32'h01000055, 8'h00}, 32, rb);
    repeat (16) @(negedge clk);
    checkOutput("ignored_frame", 17'd0, 1'b0);
    cs_n = 1'b1;
    repeat (16) @(negedge clk);
    cur_cmp = '0;
    cur_en  = 1'b0;
    applyStimulus(11, '{32'h01000055, 1'b1, 17'd85, 1'b0, 1'b0});

    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
